// File: rtl/dallanma_denetleyici_pkg.sv
// Shared micro-op codes, FSM state encodings and op-class helpers for the branch-resolution controller.
package dallanma_denetleyici_pkg;

    localparam logic [7:0] MI_JAL  = 8'h01;
    localparam logic [7:0] MI_JALR = 8'h02;
    localparam logic [7:0] MI_BEQ  = 8'h10;
    localparam logic [7:0] MI_BNE  = 8'h11;
    localparam logic [7:0] MI_BLT  = 8'h12;
    localparam logic [7:0] MI_BGE  = 8'h13;
    localparam logic [7:0] MI_BLTU = 8'h14;
    localparam logic [7:0] MI_BGEU = 8'h15;
    localparam logic [7:0] MI_ADD  = 8'h20;

    localparam logic [1:0] BASLAT    = 2'd0;
    localparam logic [1:0] BOSTA     = 2'd1;
    localparam logic [1:0] YONLENDIR = 2'd2;

    function automatic logic dallanma_mi(input logic [7:0] kod);
        case (kod)
            MI_JAL, MI_JALR, MI_BEQ, MI_BNE,
            MI_BLT, MI_BGE, MI_BLTU, MI_BGEU: dallanma_mi = 1'b1;
            default:                          dallanma_mi = 1'b0;
        endcase
    endfunction

    function automatic logic kosulsuz_mu(input logic [7:0] kod);
        kosulsuz_mu = (kod == MI_JAL) || (kod == MI_JALR);
    endfunction

endpackage

// File: rtl/dallanma_denetleyici_sayaclari.sv
// Wrap-around counters of accepted branches and mispredicts, present only with DALLANMA_SAYAC_EN.
module dallanma_sayaclari
    import dallanma_denetleyici_pkg::*;
(
    input  logic        clk_g,
    input  logic        rstn_g,
    input  logic        dallanma_darbe,
    input  logic        yanlis_darbe,
    output logic [31:0] sayac_dallanma_c,
    output logic [31:0] sayac_yanlis_c
);

    always_ff @(posedge clk_g or negedge rstn_g) begin
        if (!rstn_g) begin
            sayac_dallanma_c <= 32'd0;
            sayac_yanlis_c   <= 32'd0;
        end else begin
            if (dallanma_darbe) sayac_dallanma_c <= sayac_dallanma_c + 32'd1;
            if (yanlis_darbe)   sayac_yanlis_c   <= sayac_yanlis_c + 32'd1;
        end
    end

endmodule

// File: rtl/dallanma_denetleyici.sv
// Branch-resolution controller: mispredict detection, flush/stall, PC redirect handshake, predictor training.
// Optional branch/mispredict counters are built when DALLANMA_SAYAC_EN is defined.
//
// state     | meaning
// BASLAT    | boot redirect to SIFIRLAMA_ADRESI outstanding, execute stalled
// BOSTA     | resolving branches from execute
// YONLENDIR | mispredict redirect outstanding, execute stalled, inputs are wrong-path
module dallanma_denetleyici
    import dallanma_denetleyici_pkg::*;
#(
    parameter logic [31:0] SIFIRLAMA_ADRESI = 32'h0000_0000
) (
    input  logic        clk_g,
    input  logic        rstn_g,
    input  logic        yurut_gecerli_g,
    input  logic [7:0]  islev_kodu_g,
    input  logic [31:0] ps_g,
    input  logic        dallanma_sonuc_g,
    input  logic [31:0] hedef_ps_g,
    input  logic        tahmin_atla_g,
    input  logic [31:0] tahmin_ps_g,
    input  logic        yonlendir_hazir_g,
    output logic        yonlendir_gecerli_c,
    output logic [31:0] yonlendir_ps_c,
    output logic        temizle_c,
    output logic        durdur_c,
    output logic        hizasiz_c,
    output logic [31:0] hata_ps_c,
    output logic        guncelle_c,
    output logic [31:0] guncelle_ps_c,
    output logic        guncelle_atla_c,
    output logic [31:0] guncelle_hedef_c
`ifdef DALLANMA_SAYAC_EN
    ,
    output logic [31:0] sayac_dallanma_c,
    output logic [31:0] sayac_yanlis_c
`endif
);

    logic [1:0]  durum;
    logic        kabul;
    logic        atla;
    logic [31:0] sonraki;
    logic        yanlis;
    logic        hizasiz;
    logic        el_sikisma;

    assign kabul      = (durum == BOSTA) && yurut_gecerli_g && dallanma_mi(islev_kodu_g);
    assign atla       = kosulsuz_mu(islev_kodu_g) | dallanma_sonuc_g;
    assign sonraki    = atla ? hedef_ps_g : (ps_g + 32'd4);
    assign yanlis     = (sonraki != tahmin_ps_g) || (atla != tahmin_atla_g);
    assign hizasiz    = atla && (hedef_ps_g[1:0] != 2'b00);
    assign el_sikisma = yonlendir_gecerli_c && yonlendir_hazir_g;

    always_ff @(posedge clk_g or negedge rstn_g) begin
        if (!rstn_g) begin
            durum               <= BASLAT;
            yonlendir_gecerli_c <= 1'b0;
            yonlendir_ps_c      <= SIFIRLAMA_ADRESI;
            temizle_c           <= 1'b0;
            durdur_c            <= 1'b0;
            hizasiz_c           <= 1'b0;
            hata_ps_c           <= 32'd0;
            guncelle_c          <= 1'b0;
            guncelle_ps_c       <= 32'd0;
            guncelle_atla_c     <= 1'b0;
            guncelle_hedef_c    <= 32'd0;
        end else begin
            temizle_c  <= 1'b0;
            hizasiz_c  <= 1'b0;
            guncelle_c <= 1'b0;
            case (durum)
                BASLAT: begin
                    // valid rises on the first clock after reset; the transfer needs it already high
                    if (el_sikisma) begin
                        yonlendir_gecerli_c <= 1'b0;
                        durdur_c            <= 1'b0;
                        durum               <= BOSTA;
                    end else begin
                        yonlendir_gecerli_c <= 1'b1;
                        yonlendir_ps_c      <= SIFIRLAMA_ADRESI;
                        durdur_c            <= 1'b1;
                    end
                end
                BOSTA: begin
                    if (kabul) begin
                        guncelle_c       <= 1'b1;
                        guncelle_ps_c    <= ps_g;
                        guncelle_atla_c  <= atla;
                        guncelle_hedef_c <= hedef_ps_g;
                        if (hizasiz) begin
                            hizasiz_c <= 1'b1;
                            hata_ps_c <= hedef_ps_g;
                        end else if (yanlis) begin
                            temizle_c           <= 1'b1;
                            yonlendir_gecerli_c <= 1'b1;
                            yonlendir_ps_c      <= sonraki;
                            durdur_c            <= 1'b1;
                            durum               <= YONLENDIR;
                        end
                    end
                end
                YONLENDIR: begin
                    if (el_sikisma) begin
                        yonlendir_gecerli_c <= 1'b0;
                        durdur_c            <= 1'b0;
                        durum               <= BOSTA;
                    end
                end
                default: begin
                    yonlendir_gecerli_c <= 1'b0;
                    durdur_c            <= 1'b0;
                    durum               <= BASLAT;
                end
            endcase
        end
    end

`ifdef DALLANMA_SAYAC_EN
    dallanma_sayaclari u_sayaclar (
        .clk_g            (clk_g),
        .rstn_g           (rstn_g),
        .dallanma_darbe   (guncelle_c),
        .yanlis_darbe     (temizle_c),
        .sayac_dallanma_c (sayac_dallanma_c),
        .sayac_yanlis_c   (sayac_yanlis_c)
    );
`endif

endmodule

// File: tb/tb_dallanma_denetleyici.sv
// Self-checking bench for dallanma_denetleyici: directed scenarios followed by random branches against a reference model.
module tb_dallanma_denetleyici;
    import dallanma_denetleyici_pkg::*;

    localparam logic [31:0] BOOT = 32'h0000_0800;

    logic        clk_g = 1'b0;
    logic        rstn_g = 1'b0;
    logic        yurut_gecerli_g = 1'b0;
    logic [7:0]  islev_kodu_g = 8'h00;
    logic [31:0] ps_g = 32'd0;
    logic        dallanma_sonuc_g = 1'b0;
    logic [31:0] hedef_ps_g = 32'd0;
    logic        tahmin_atla_g = 1'b0;
    logic [31:0] tahmin_ps_g = 32'd0;
    logic        yonlendir_hazir_g = 1'b0;
    logic        yonlendir_gecerli_c;
    logic [31:0] yonlendir_ps_c;
    logic        temizle_c;
    logic        durdur_c;
    logic        hizasiz_c;
    logic [31:0] hata_ps_c;
    logic        guncelle_c;
    logic [31:0] guncelle_ps_c;
    logic        guncelle_atla_c;
    logic [31:0] guncelle_hedef_c;
`ifdef DALLANMA_SAYAC_EN
    logic [31:0] sayac_dallanma_c;
    logic [31:0] sayac_yanlis_c;
`endif

    dallanma_denetleyici #(.SIFIRLAMA_ADRESI(BOOT)) dut (
        .clk_g               (clk_g),
        .rstn_g              (rstn_g),
        .yurut_gecerli_g     (yurut_gecerli_g),
        .islev_kodu_g        (islev_kodu_g),
        .ps_g                (ps_g),
        .dallanma_sonuc_g    (dallanma_sonuc_g),
        .hedef_ps_g          (hedef_ps_g),
        .tahmin_atla_g       (tahmin_atla_g),
        .tahmin_ps_g         (tahmin_ps_g),
        .yonlendir_hazir_g   (yonlendir_hazir_g),
        .yonlendir_gecerli_c (yonlendir_gecerli_c),
        .yonlendir_ps_c      (yonlendir_ps_c),
        .temizle_c           (temizle_c),
        .durdur_c            (durdur_c),
        .hizasiz_c           (hizasiz_c),
        .hata_ps_c           (hata_ps_c),
        .guncelle_c          (guncelle_c),
        .guncelle_ps_c       (guncelle_ps_c),
        .guncelle_atla_c     (guncelle_atla_c),
        .guncelle_hedef_c    (guncelle_hedef_c)
`ifdef DALLANMA_SAYAC_EN
        ,
        .sayac_dallanma_c    (sayac_dallanma_c),
        .sayac_yanlis_c      (sayac_yanlis_c)
`endif
    );

    always #5 clk_g = ~clk_g;

    int toplam = 0;
    int hatali = 0;

    // reference model: what the outputs should show after the next clock edge
    logic        m_boot, m_gecerli, m_durdur, m_temizle, m_hizasiz, m_gunc, m_gatla;
    logic [31:0] m_ps, m_hata_ps, m_gps, m_ghedef;
    logic [31:0] m_say_d, m_say_y;

    logic [7:0]  islev_tablo [0:10];

    task automatic denetle(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        toplam++;
        if (gozlenen !== beklenen) begin
            hatali++;
            $display("FAIL %s: gozlenen=%h beklenen=%h (t=%0t)", etiket, gozlenen, beklenen, $time);
        end
    endtask

    task automatic model_sifirla();
        m_boot = 1'b1; m_gecerli = 1'b0; m_durdur = 1'b0; m_ps = BOOT;
        m_temizle = 1'b0; m_hizasiz = 1'b0; m_hata_ps = 32'd0;
        m_gunc = 1'b0; m_gps = 32'd0; m_gatla = 1'b0; m_ghedef = 32'd0;
        m_say_d = 32'd0; m_say_y = 32'd0;
    endtask

    task automatic model_adim(input logic yv, input logic [7:0] op, input logic [31:0] ps,
                              input logic snc, input logic [31:0] hdf, input logic ta,
                              input logic [31:0] tps, input logic hz);
        logic        atla;
        logic [31:0] sonraki;
        if (m_gunc)    m_say_d = m_say_d + 32'd1;
        if (m_temizle) m_say_y = m_say_y + 32'd1;
        m_gunc = 1'b0; m_temizle = 1'b0; m_hizasiz = 1'b0;
        if (m_boot) begin
            m_gecerli = 1'b1; m_durdur = 1'b1; m_boot = 1'b0;
        end else if (m_gecerli) begin
            if (hz) begin m_gecerli = 1'b0; m_durdur = 1'b0; end
        end else if (yv && (op inside {MI_JAL, MI_JALR, MI_BEQ, MI_BNE, MI_BLT, MI_BGE, MI_BLTU, MI_BGEU})) begin
            atla    = (op == MI_JAL) || (op == MI_JALR) || snc;
            sonraki = atla ? hdf : ps + 32'd4;
            m_gunc = 1'b1; m_gps = ps; m_gatla = atla; m_ghedef = hdf;
            if (atla && (hdf % 4 != 0)) begin
                m_hizasiz = 1'b1; m_hata_ps = hdf;
            end else if (sonraki != tps || atla != ta) begin
                m_temizle = 1'b1; m_gecerli = 1'b1; m_durdur = 1'b1; m_ps = sonraki;
            end
        end
    endtask

    task automatic kontrol();
        denetle("gecerli", {31'd0, yonlendir_gecerli_c}, {31'd0, m_gecerli});
        denetle("yon_ps", yonlendir_ps_c, m_ps);
        denetle("durdur", {31'd0, durdur_c}, {31'd0, m_durdur});
        denetle("temizle", {31'd0, temizle_c}, {31'd0, m_temizle});
        denetle("hizasiz", {31'd0, hizasiz_c}, {31'd0, m_hizasiz});
        denetle("guncelle", {31'd0, guncelle_c}, {31'd0, m_gunc});
        if (m_hizasiz) denetle("hata_ps", hata_ps_c, m_hata_ps);
        if (m_gunc) begin
            denetle("gunc_ps", guncelle_ps_c, m_gps);
            denetle("gunc_atla", {31'd0, guncelle_atla_c}, {31'd0, m_gatla});
            denetle("gunc_hedef", guncelle_hedef_c, m_ghedef);
        end
`ifdef DALLANMA_SAYAC_EN
        denetle("sayac_dallanma", sayac_dallanma_c, m_say_d);
        denetle("sayac_yanlis", sayac_yanlis_c, m_say_y);
`endif
    endtask

    task automatic saat(input logic yv, input logic [7:0] op, input logic [31:0] ps,
                        input logic snc, input logic [31:0] hdf, input logic ta,
                        input logic [31:0] tps, input logic hz);
        yurut_gecerli_g = yv; islev_kodu_g = op; ps_g = ps; dallanma_sonuc_g = snc;
        hedef_ps_g = hdf; tahmin_atla_g = ta; tahmin_ps_g = tps; yonlendir_hazir_g = hz;
        model_adim(yv, op, ps, snc, hdf, ta, tps, hz);
        @(posedge clk_g);
        #1;
        kontrol();
    endtask

    task automatic bos(input logic hz);
        saat(1'b0, MI_ADD, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, hz);
    endtask

    task automatic sifirla_kontrol();
        denetle("rst_gecerli", {31'd0, yonlendir_gecerli_c}, 32'd0);
        denetle("rst_ps", yonlendir_ps_c, BOOT);
        denetle("rst_durdur", {31'd0, durdur_c}, 32'd0);
        denetle("rst_temizle", {31'd0, temizle_c}, 32'd0);
        denetle("rst_guncelle", {31'd0, guncelle_c}, 32'd0);
        denetle("rst_hizasiz", {31'd0, hizasiz_c}, 32'd0);
    endtask

    initial begin
        logic        yv, snc, ta, hz, atla;
        logic [7:0]  op;
        logic [31:0] ps, hdf, tps, sonraki, sabit_ps;

        islev_tablo[0] = MI_JAL;  islev_tablo[1] = MI_JALR; islev_tablo[2] = MI_BEQ;
        islev_tablo[3] = MI_BNE;  islev_tablo[4] = MI_BLT;  islev_tablo[5] = MI_BGE;
        islev_tablo[6] = MI_BLTU; islev_tablo[7] = MI_BGEU; islev_tablo[8] = MI_ADD;
        islev_tablo[9] = 8'h00;   islev_tablo[10] = 8'h30;

        // reset and boot redirect held while fetch is not ready
        model_sifirla();
        #12;
        sifirla_kontrol();
        @(negedge clk_g);
        rstn_g = 1'b1;
        bos(1'b0); bos(1'b0); bos(1'b0);
        denetle("boot_tutuldu", {31'd0, yonlendir_gecerli_c}, 32'd1);
        bos(1'b1);
        denetle("boot_bitti", {31'd0, durdur_c}, 32'd0);

        // taken BEQ predicted not taken
        saat(1'b1, MI_BEQ, 32'h100, 1'b1, 32'h140, 1'b0, 32'h104, 1'b0);
        denetle("t2_ps", yonlendir_ps_c, 32'h140);
        denetle("t2_temizle", {31'd0, temizle_c}, 32'd1);
        bos(1'b0);
        bos(1'b1);

        // not-taken BNE correctly predicted
        saat(1'b1, MI_BNE, 32'h200, 1'b0, 32'h260, 1'b0, 32'h204, 1'b0);
        denetle("t3_temizle", {31'd0, temizle_c}, 32'd0);
        bos(1'b0);
`ifdef DALLANMA_SAYAC_EN
        denetle("t6_dallanma", sayac_dallanma_c, 32'd2);
        denetle("t6_yanlis", sayac_yanlis_c, 32'd1);
`endif

        // misaligned JALR, then wrap cases around the top of the address space
        saat(1'b1, MI_JALR, 32'h300, 1'b0, 32'h302, 1'b1, 32'h302, 1'b0);
        denetle("t4_hata_ps", hata_ps_c, 32'h302);
        saat(1'b1, MI_JAL, 32'hFFFF_FFFC, 1'b0, 32'h400, 1'b0, 32'h0, 1'b0);
        denetle("t4_jal_ps", yonlendir_ps_c, 32'h400);
        bos(1'b1);
        saat(1'b1, MI_BNE, 32'hFFFF_FFFC, 1'b0, 32'h500, 1'b1, 32'h500, 1'b0);
        denetle("t4_sarma_ps", yonlendir_ps_c, 32'h0);
        bos(1'b1);

        // wrong-path branches while the redirect waits
        saat(1'b1, MI_BLT, 32'h600, 1'b1, 32'h680, 1'b0, 32'h604, 1'b0);
        sabit_ps = 32'h680;
        for (int i = 0; i < 4; i++)
            saat(1'b1, MI_BEQ, 32'h700 + i * 4, 1'b1, 32'h900, 1'b0, 32'h704, 1'b0);
        denetle("t5_ps_sabit", yonlendir_ps_c, sabit_ps);
        saat(1'b1, MI_BEQ, 32'h710, 1'b1, 32'h900, 1'b0, 32'h714, 1'b1);
        denetle("t5_yok_sayildi", {31'd0, guncelle_c}, 32'd0);

        // reset while a redirect is pending
        saat(1'b1, MI_BGE, 32'hA00, 1'b1, 32'hA40, 1'b0, 32'hA04, 1'b0);
        #2 rstn_g = 1'b0;
        #1;
        model_sifirla();
        sifirla_kontrol();
        @(negedge clk_g);
        rstn_g = 1'b1;
        bos(1'b1);
        denetle("yeniden_boot", yonlendir_ps_c, BOOT);
        bos(1'b1);

        for (int n = 0; n < 600; n++) begin
            yv  = ($urandom_range(0, 9) < 8);
            op  = islev_tablo[$urandom_range(0, 10)];
            ps  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            snc = 1'($urandom_range(0, 1));
            hdf = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) hdf = hdf | 32'($urandom_range(1, 3));
            atla    = (op == MI_JAL) || (op == MI_JALR) || snc;
            sonraki = atla ? hdf : ps + 32'd4;
            case ($urandom_range(0, 3))
                0, 1: begin ta = atla;  tps = sonraki; end
                2:    begin ta = ~atla; tps = sonraki; end
                default: begin ta = 1'($urandom_range(0, 1)); tps = $urandom & 32'hFFFF_FFFC; end
            endcase
            hz = ($urandom_range(0, 2) == 0);
            saat(yv, op, ps, snc, hdf, ta, tps, hz);
        end

        $display("test done: total=%0d bad=%0d", toplam, hatali);
        $finish;
    end

endmodule
